// File: rtl/sisc_pkg.sv
// sisc_pkg: encodings and bus widths shared by the SISC blocks (rf/alu/pc/mem arbiter).
// Contents: default address/data widths, memory arbiter state encoding and
//           access owner encoding.
package sisc_pkg;

  localparam int SISC_ADDR_W = 16;
  localparam int SISC_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/sisc_mem_arbiter_if.sv
// sisc_mem_arbiter_if: requester and memory-macro signals around the memory arbiter.
// Ports: fetch req/addr, data req/we/addr/wdata, mem_rdata in; mem_addr/we/wdata,
//        f_ack/d_ack, rdata, busy out. slave = arbiter side, master = requester/memory side.
interface sisc_mem_arbiter_if #(
  parameter int ADDR_W = sisc_pkg::SISC_ADDR_W,
  parameter int DATA_W = sisc_pkg::SISC_DATA_W
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              f_ack;
  logic              d_ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output mem_addr, mem_we, mem_wdata, f_ack, d_ack, rdata, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  mem_addr, mem_we, mem_wdata, f_ack, d_ack, rdata, busy
  );
endinterface

// File: rtl/sisc_arb_pick.sv
// sisc_arb_pick: combinational winner select between fetch and data requesters.
// Ports: f_req, d_req, burst (consecutive data grants seen while fetch waited) in;
//        grant (any request), owner (winner) out.
module sisc_arb_pick
  import sisc_pkg::*;
#(
  parameter int D_BURST = 3,
  parameter int BURST_W = $clog2(D_BURST + 1)
) (
  input  logic               f_req,
  input  logic               d_req,
  input  logic [BURST_W-1:0] burst,
  output logic               grant,
  output arb_owner_e         owner
);

  // Data normally wins; a fetch that has watched D_BURST data grants goes first.
  always_comb begin
    grant = f_req | d_req;
    owner = OWN_D;
    if (f_req && (!d_req || burst == BURST_W'(D_BURST))) begin
      owner = OWN_F;
    end
  end

endmodule

// File: rtl/sisc_mem_arbiter.sv
// sisc_mem_arbiter: shares the single-ported main memory between instruction fetch and data access.
// Ports: clk, rst_f (async, active-low), bus (slave modport: requests in, memory strobes,
//        acks, registered rdata and busy out). Each access: IDLE grant, MEM_LAT ACCESS cycles, RESP ack.
module sisc_mem_arbiter
  import sisc_pkg::*;
#(
  parameter int ADDR_W  = SISC_ADDR_W,
  parameter int DATA_W  = SISC_DATA_W,
  parameter int MEM_LAT = 2,
  parameter int D_BURST = 3
) (
  input  logic                clk,
  input  logic                rst_f,
  sisc_mem_arbiter_if.slave   bus
);

  localparam int WAIT_W  = $clog2(MEM_LAT + 1);
  localparam int BURST_W = $clog2(D_BURST + 1);

  arb_state_e         state;
  arb_state_e         state_nxt;
  arb_owner_e         own_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [BURST_W-1:0] burst_q;

  logic               grant;
  arb_owner_e         pick_own;

  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_wdata;
  logic               f_ack;
  logic               d_ack;

  sisc_arb_pick #(
    .D_BURST (D_BURST),
    .BURST_W (BURST_W)
  ) u_pick (
    .f_req (bus.f_req),
    .d_req (bus.d_req),
    .burst (burst_q),
    .grant (grant),
    .owner (pick_own)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      own_q   <= OWN_F;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wait_q  <= '0;
      burst_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant) begin
            own_q  <= pick_own;
            wait_q <= WAIT_W'(1);
            if (pick_own == OWN_D) begin
              addr_q  <= bus.d_addr;
              we_q    <= bus.d_we;
              wdata_q <= bus.d_wdata;
            end else begin
              addr_q  <= bus.f_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
          end
          // Count data grants only while a fetch is waiting; any fetch grant or
          // an IDLE cycle without fetch request restarts the count.
          if (!bus.f_req || pick_own == OWN_F) begin
            burst_q <= '0;
          end else if (burst_q != BURST_W'(D_BURST)) begin
            burst_q <= burst_q + 1'b1;
          end
        end
        ARB_ACCESS: begin
          if (wait_q != WAIT_W'(MEM_LAT)) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ARB_RESP: begin
          // rdata becomes visible on the edge that closes the ack cycle.
          if (!we_q) begin
            rdata_q <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (grant) begin
          state_nxt = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        // Strobe only on the first ACCESS cycle so a store writes exactly once.
        mem_we    = we_q && (wait_q == WAIT_W'(1));
        if (wait_q == WAIT_W'(MEM_LAT)) begin
          state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        f_ack     = (own_q == OWN_F);
        d_ack     = (own_q == OWN_D);
        state_nxt = ARB_IDLE;
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = mem_wdata;
  assign bus.f_ack     = f_ack;
  assign bus.d_ack     = d_ack;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state != ARB_IDLE);

endmodule

// File: tb/tb_sisc_mem_arbiter.sv
// tb_sisc_mem_arbiter: directed and randomized checks of the memory arbiter against a
// transaction-level model (grant cycle, ack cycle, memory image, starvation count).
// Also runs a MEM_LAT=1 instance for latency and back-to-back spacing.
module tb_sisc_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;
  localparam int D_BURST = 3;

  logic clk;
  logic rst_f;
  logic mem_clr;

  sisc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();
  sisc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc1 ();

  sisc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .D_BURST(D_BURST))
    u_dut (.clk(clk), .rst_f(rst_f), .bus(ifc));

  sisc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1), .D_BURST(D_BURST))
    u_dut1 (.clk(clk), .rst_f(rst_f), .bus(ifc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    if (a == 16) return 32'h8812_0003;
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0101);
  endfunction

  // Memory macro model: write on strobe, read data appears MEM_LAT cycles after the address.
  logic [31:0] dut_mem [256];
  logic [31:0] pipe [MEM_LAT];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) dut_mem[i] <= init_val(i);
    end else if (ifc.mem_we) begin
      dut_mem[ifc.mem_addr[7:0]] <= ifc.mem_wdata;
    end
    pipe[0] <= dut_mem[ifc.mem_addr[7:0]];
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ifc.mem_rdata  = pipe[MEM_LAT-1];
  assign ifc1.mem_rdata = 32'h8812_0003;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = 0;

  // Reference model state
  logic [31:0] ref_mem [256];
  bit          m_act = 0;
  int          m_g = 0;
  bit          m_own_d = 0;
  logic [15:0] m_addr = '0;
  logic        m_we = 0;
  logic [31:0] m_wdata = '0;
  int          m_burst = 0;
  logic [31:0] m_rdata = '0;

  // Requester agents
  bit f_on = 0, d_on = 0, f_rnd = 0, d_rnd = 0;
  int f_cnt = 0, d_cnt = 0, f_wt = 0, d_wt = 0;
  int f_gmin = 0, f_gmax = 0, d_gmin = 0, d_gmax = 0;
  logic [15:0] f_addr_v = '0, d_addr_v = '0;
  logic        d_we_v = 0;
  logic [31:0] d_wdata_v = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic agents();
    if (f_on && ifc.f_ack) begin
      f_cnt--; f_on = 0; f_wt = $urandom_range(f_gmax, f_gmin);
    end else if (!f_on && f_wt > 0) begin
      f_wt--;
    end
    if (!f_on && f_cnt > 0 && f_wt == 0) begin
      f_on = 1;
      if (f_rnd) f_addr_v = 16'($urandom);
    end
    if (d_on && ifc.d_ack) begin
      d_cnt--; d_on = 0; d_wt = $urandom_range(d_gmax, d_gmin);
    end else if (!d_on && d_wt > 0) begin
      d_wt--;
    end
    if (!d_on && d_cnt > 0 && d_wt == 0) begin
      d_on = 1;
      if (d_rnd) begin
        d_we_v = 1'($urandom); d_addr_v = 16'($urandom); d_wdata_v = $urandom;
      end
    end
  endtask

  task automatic step();
    logic [31:0] e_addr, e_wdata;
    logic e_we, e_fa, e_da, e_busy, fwin;
    @(posedge clk); #1;
    check("rdata", ifc.rdata, m_rdata);
    ifc.f_req = f_on; ifc.f_addr = f_addr_v;
    ifc.d_req = d_on; ifc.d_we = d_we_v; ifc.d_addr = d_addr_v; ifc.d_wdata = d_wdata_v;
    @(negedge clk);
    e_addr = '0; e_wdata = '0; e_we = 0; e_fa = 0; e_da = 0; e_busy = 0; fwin = 0;
    if (!m_act) begin
      if (f_on || d_on) begin
        fwin    = f_on && (!d_on || m_burst == D_BURST);
        m_act   = 1; m_g = cyc; m_own_d = !fwin;
        m_addr  = fwin ? f_addr_v : d_addr_v;
        m_we    = fwin ? 1'b0 : d_we_v;
        m_wdata = fwin ? 32'h0 : d_wdata_v;
        if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
      end
      if (!f_on || fwin) m_burst = 0;
      else if (m_burst < D_BURST) m_burst++;
    end else begin
      e_busy = 1; e_addr = 32'(m_addr); e_wdata = m_wdata;
      if (cyc == m_g + 1) e_we = m_we;
      if (cyc == m_g + MEM_LAT + 1) begin
        e_fa = !m_own_d; e_da = m_own_d;
        if (!m_we) m_rdata = ref_mem[m_addr[7:0]];
        m_act = 0;
      end
    end
    check("busy", ifc.busy, e_busy);
    check("f_ack", ifc.f_ack, e_fa);
    check("d_ack", ifc.d_ack, e_da);
    check("mem_we", ifc.mem_we, e_we);
    check("mem_addr", ifc.mem_addr, e_addr);
    check("mem_wdata", ifc.mem_wdata, e_wdata);
    last_cyc = cyc;
    cyc++;
    agents();
  endtask

  task automatic run_until_idle(input int max);
    bit idle = 0;
    for (int i = 0; i < max && !idle; i++) begin
      step();
      idle = !m_act && f_cnt == 0 && d_cnt == 0 && !f_on && !d_on;
    end
    check("idle_reached", 32'(idle), 32'd1);
    step();
  endtask

  initial begin
    rst_f = 0; mem_clr = 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ifc.f_req = 0; ifc.f_addr = '0; ifc.d_req = 0; ifc.d_we = 0; ifc.d_addr = '0; ifc.d_wdata = '0;
    ifc1.f_req = 0; ifc1.f_addr = 16'h0010; ifc1.d_req = 0; ifc1.d_we = 0; ifc1.d_addr = '0; ifc1.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", ifc.busy, 0);
    check("rst_ack", {ifc.f_ack, ifc.d_ack}, 0);
    check("rst_mem_addr", ifc.mem_addr, 0);
    check("rst_rdata", ifc.rdata, 0);
    mem_clr = 0;
    @(negedge clk); rst_f = 1;

    // Fetch only from 0x0010
    f_rnd = 0; f_addr_v = 16'h0010; f_cnt = 1;
    run_until_idle(20);
    check("fetch_rdata", ifc.rdata, 32'h8812_0003);

    // Store DEADBEEF to 0x0040
    d_rnd = 0; d_we_v = 1; d_addr_v = 16'h0040; d_wdata_v = 32'hDEAD_BEEF; d_cnt = 1;
    run_until_idle(20);

    // Simultaneous load (reads back the store) and fetch
    d_we_v = 0; d_gmin = 1; d_gmax = 1; d_cnt = 1; f_cnt = 1;
    run_until_idle(30);
    check("load_rdata_after_fetch", ifc.rdata, 32'h8812_0003);

    // Starvation limit: data re-requests back-to-back while fetch waits
    d_rnd = 1; d_gmin = 0; d_gmax = 0; d_cnt = 5; f_cnt = 1;
    run_until_idle(60);

    // Randomized traffic
    f_rnd = 1; f_gmin = 0; f_gmax = 3; d_gmin = 0; d_gmax = 1;
    f_cnt = 40; d_cnt = 60;
    run_until_idle(3000);

    // Reset during the second ACCESS cycle of a load
    d_rnd = 0; d_we_v = 0; d_addr_v = 16'h0020; d_cnt = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_act && last_cyc == m_g + 2) break;
    end
    check("reached_access2", 32'(m_act && last_cyc == m_g + 2), 32'd1);
    rst_f = 0;
    #1;
    check("arst_busy", ifc.busy, 0);
    check("arst_mem_addr", ifc.mem_addr, 0);
    check("arst_ack", {ifc.f_ack, ifc.d_ack}, 0);
    check("arst_rdata", ifc.rdata, 0);
    m_act = 0; m_burst = 0; m_rdata = '0;
    f_on = 0; d_on = 0; f_cnt = 0; d_cnt = 0; f_wt = 0; d_wt = 0;
    ifc.f_req = 0; ifc.d_req = 0;
    repeat (2) begin
      @(negedge clk);
      check("arst_hold_ack", {ifc.f_ack, ifc.d_ack}, 0);
    end
    rst_f = 1;
    f_rnd = 0; f_addr_v = 16'h0010; f_gmin = 0; f_gmax = 0; f_cnt = 1;
    run_until_idle(20);
    check("post_rst_fetch", ifc.rdata, 32'h8812_0003);

    // MEM_LAT=1 instance: fetch held high, acks every third cycle
    @(posedge clk); #1;
    ifc1.f_req = 1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("l1_f_ack", ifc1.f_ack, 32'(c % 3 == 2));
      check("l1_busy", ifc1.busy, 32'(c % 3 != 0));
      @(posedge clk); #1;
    end
    ifc1.f_req = 0;
    check("l1_rdata", ifc1.rdata, 32'h8812_0003);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
